pixel_stream_rx: RTL

PIXEL_STREAM_RX -- requirements
Module: pixel_stream_rx

---
 rtl/pixel_pkg.sv | 38 +++
 rtl/pixel_fifo.sv | 59 +++++
 rtl/pixel_stream_rx.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/pixel_pkg.sv
// Shared types and constants for the pixel stream receiver.
// The gray helper is only referenced when PIXEL_GRAY_EN is defined.
package pixel_pkg;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef struct packed {
        rgb_t data;
        logic sof;
        logic eol;
    } pix_beat_t;

    localparam int BEAT_W = $bits(pix_beat_t);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } rx_state_t;

    localparam logic [7:0] GRAY_COEF_R = 8'd77;
    localparam logic [7:0] GRAY_COEF_G = 8'd150;
    localparam logic [7:0] GRAY_COEF_B = 8'd29;

    // Worst case 255*(77+150+29) = 65280, so the 16-bit sum never wraps.
    function automatic logic [7:0] gray_of(input rgb_t p);
        logic [15:0] sum;
        sum = ({8'd0, GRAY_COEF_R} * {8'd0, p.r})
            + ({8'd0, GRAY_COEF_G} * {8'd0, p.g})
            + ({8'd0, GRAY_COEF_B} * {8'd0, p.b});
        return sum[15:8];
    endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Output buffer for the pixel stream receiver: DEPTH entries of {data, sof, eol}.
// Push into a full FIFO is accepted only when a pop happens in the same cycle.
module pixel_fifo
    import pixel_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [BEAT_W-1:0]        wdata,
    input  logic                     pop,
    output logic [BEAT_W-1:0]        rdata,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [BEAT_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       cnt;
    logic              do_push;
    logic              do_pop;

    assign do_pop  = pop && (cnt != '0);
    assign do_push = push && ((cnt != FULL_CNT) || do_pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign rdata = mem[rd_ptr];
    assign empty = (cnt == '0);
    assign count = cnt;

endmodule

// File: rtl/pixel_stream_rx.sv
// Pixel stream receiver: frame tracking, 2-stage pipeline and output FIFO.
// Define PIXEL_GRAY_EN to replace each pixel by its luma {Y,Y,Y}.
//
// state  | meaning
// IDLE   | waiting for the first sof beat after reset
// ACTIVE | inside a frame, counting x/y
// DONE   | last pixel accepted; waiting for the next sof
module pixel_stream_rx
    import pixel_pkg::*;
#(
    parameter int IMG_W      = 240,
    parameter int IMG_H      = 240,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [23:0] s_data,
    input  logic        s_sof,
    input  logic        s_eol,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [23:0] m_data,
    output logic        m_sof,
    output logic        m_eol,
    output logic        done,
    output logic        err,
    output logic [31:0] pix_cnt
);

    localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
    localparam logic [CW:0]   CREDIT = (CW + 1)'(FIFO_DEPTH);

    rx_state_t   state_q, state_d;
    logic [XW-1:0] x_q, x_d, px;
    logic [YW-1:0] y_q, y_d, py;
    logic [31:0] cnt_q, cnt_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        rdy_en_q;
    logic        accept;
    logic        fwd;
    pix_beat_t   beat_in;

    logic        v1, v2;
    pix_beat_t   b1, b2, b1_conv;
    logic [BEAT_W-1:0] fifo_rdata;
    logic        fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [CW:0] occupancy;
    pix_beat_t   head;

    assign accept = s_valid && s_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            x_q      <= '0;
            y_q      <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            rdy_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            err_q    <= err_d;
            rdy_en_q <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        err_d   = err_q;
        fwd     = 1'b0;
        px      = x_q;
        py      = y_q;
        if (accept) begin
            if (!s_sof && (state_q != ACTIVE)) begin
                err_d = 1'b1;
            end else begin
                fwd = 1'b1;
                if (s_sof) begin
                    // A sof inside a frame aborts it; the beat restarts at (0,0).
                    if (state_q == ACTIVE) begin
                        err_d = 1'b1;
                    end
                    px     = '0;
                    py     = '0;
                    cnt_d  = 32'd1;
                    done_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
                if (s_eol != (px == X_LAST)) begin
                    err_d = 1'b1;
                end
                state_d = ACTIVE;
                if (px == X_LAST) begin
                    x_d = '0;
                    if (py == Y_LAST) begin
                        y_d     = '0;
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        y_d = py + 1'b1;
                    end
                end else begin
                    x_d = px + 1'b1;
                    y_d = py;
                end
            end
        end
    end

    assign beat_in.data = rgb_t'(s_data);
    assign beat_in.sof  = (px == '0) && (py == '0);
    assign beat_in.eol  = (px == X_LAST);

    always_comb begin
        b1_conv = b1;
`ifdef PIXEL_GRAY_EN
        b1_conv.data = rgb_t'({3{gray_of(b1.data)}});
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            b1 <= '0;
            b2 <= '0;
        end else begin
            v1 <= fwd;
            v2 <= v1;
            if (fwd) begin
                b1 <= beat_in;
            end
            if (v1) begin
                b2 <= b1_conv;
            end
        end
    end

    pixel_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (v2),
        .wdata   (b2),
        .pop     (m_ready),
        .rdata   (fifo_rdata),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Beats in flight count against credit so a stalled sink never loses one.
    assign occupancy = (CW + 1)'(fifo_count) + (CW + 1)'(v1) + (CW + 1)'(v2);
    assign s_ready   = rdy_en_q && (occupancy < CREDIT);

    assign head    = pix_beat_t'(fifo_rdata);
    assign m_valid = !fifo_empty;
    assign m_data  = head.data;
    assign m_sof   = head.sof;
    assign m_eol   = head.eol;
    assign done    = done_q;
    assign err     = err_q;
    assign pix_cnt = cnt_q;

endmodule
